// File: rtl/spm_pkg.sv
// Shared definitions for the serial/parallel multiplier driver.
//   state_t   : driver FSM encoding (IDLE, RUN, DONE), 2 bits
//   cnt_width : width of the run counter, which must hold 0..2*bits
package spm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // The counter must reach 2*bits without wrapping inside a run.
   function automatic int unsigned cnt_width(input int unsigned b);
      return $clog2(2 * b + 1);
   endfunction

endpackage

// File: rtl/spm_driver.sv
// Host-side initiator for one serial/parallel multiplier (spm).
// Accepts an operand pair over a valid/ready handshake, streams x LSB-first
// to the spm while holding a, and deserializes the serial product into a
// 2*bits-wide result returned over a second valid/ready handshake.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   operand handshake; in_ready is high only in IDLE
//   in_x, in_a          unsigned multiplicand / multiplier
//   out_valid/out_ready product handshake
//   out_p               unsigned product in_x*in_a, held until next capture
//   mul_x               serial multiplicand to spm.x
//   mul_a               parallel multiplier to spm.a
//   mul_y               serial product from spm.y
module spm_driver
   import spm_pkg::*;
#(
   parameter int unsigned bits = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [bits-1:0]   in_x,
   input  logic [bits-1:0]   in_a,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [2*bits-1:0] out_p,
   output logic              mul_x,
   output logic [bits-1:0]   mul_a,
   input  logic              mul_y
);

   localparam int unsigned CW = cnt_width(bits);
   localparam logic [CW-1:0] CNT_LAST = CW'(2 * bits);

   state_t              state_q;
   logic [bits-1:0]     x_q;
   logic [bits-1:0]     a_q;
   logic [CW-1:0]       cnt_q;
   logic [2*bits-1:0]   p_q;
   logic                mul_x_q;
   logic                in_ready_q;
   logic                out_valid_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         x_q         <= '0;
         a_q         <= '0;
         cnt_q       <= '0;
         p_q         <= '0;
         mul_x_q     <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid && in_ready_q) begin
                  // Bit 0 goes straight to mul_x so it is present in run cycle 0;
                  // the remaining bits wait in the shift register.
                  mul_x_q    <= in_x[0];
                  x_q        <= in_x >> 1;
                  a_q        <= in_a;
                  cnt_q      <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= RUN;
               end
            end

            RUN: begin
               // The spm registers its output, so product bit c-1 is on
               // mul_y during cycle c; nothing useful arrives in cycle 0.
               if (cnt_q != '0) begin
                  p_q <= {mul_y, p_q[2*bits-1:1]};
               end
               // Zero fill of the shift register provides the zero extension
               // of x for cycles bits..2*bits.
               mul_x_q <= x_q[0];
               x_q     <= x_q >> 1;
               if (cnt_q == CNT_LAST) begin
                  mul_x_q     <= 1'b0;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end

            default: begin
               mul_x_q     <= 1'b0;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_p     = p_q;
   assign mul_x     = mul_x_q;
   assign mul_a     = a_q;

endmodule

// File: doc/spm_driver.md
Name: spm_driver

Overview:
- Host-side initiator for the serial/parallel multiplier (spm).
- Accepts a parallel multiplicand x and multiplier a through a valid/ready handshake.
- Serializes x LSB-first onto the multiplier's serial input while holding a stable, then deserializes the serial product into a 2*bits-wide parallel result.
- Sits between a parallel bus-side client and one spm instance; the integrating top connects the two and shares clk/rst with both.

Parameters:
bits, 32, operand width; must match the connected spm's bits (>=2).

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset; shared with the connected spm
in_valid  in  1  operand pair valid
in_ready  out  1  driver can accept operands (IDLE only)
in_x  in  bits  multiplicand, unsigned
in_a  in  bits  multiplier, unsigned
out_valid  out  1  product valid
out_ready  in  1  client accepts product
out_p  out  2*bits  product in_x*in_a, unsigned
mul_x  out  1  serial multiplicand to spm.x
mul_a  out  bits  parallel multiplier to spm.a
mul_y  in  1  serial product from spm.y

Behaviour:
- Reset (rst low, asynchronous, any state including mid-run):
  - state=IDLE; all registers cleared.
  - out_valid=0, out_p=0, mul_x=0, mul_a=0, in_ready=1 after reset release.
  - The connected spm is cleared by the same rst, so no drain is needed after reset.
- States: IDLE, RUN, DONE; encoded 2 bits.
- IDLE:
  - in_ready=1, mul_x=0.
  - On the edge where in_valid&in_ready: latch in_x into the x shift register and in_a into the a register, clear the cycle counter c=0, go to RUN.
- RUN, lasts exactly 2*bits+1 cycles, c=0..2*bits:
  - mul_x is registered and equals x bit c during cycle c; 0 for c>=bits (zero-extension).
  - mul_a holds the latched a for the whole run and into DONE.
  - At the end of each cycle c>=1, sample mul_y as product bit c-1: shift it into the MSB of the 2*bits product shift register (right shift). This accounts for the spm's 1-cycle output register offset: product bit p appears on mul_y in cycle p+1.
  - When c==2*bits, all 2*bits product bits are captured; go to DONE.
  - Counter width is clog2(2*bits+1); no wrap inside a run.
- DONE:
  - out_valid=1; out_p holds the product; mul_x=0; in_ready=0.
  - Wait indefinitely for out_ready. On out_valid&out_ready, go to IDLE. out_p keeps its value until the next capture; out_valid drops.
  - A new operand is accepted no earlier than the cycle after the handshake (no same-cycle turnaround).
- Drain guarantee: x*a < 2^(2*bits), so after the run every spm carry and output register is zero. Back-to-back operations therefore need no spm clear.
- in_x/in_a changes while not accepted are ignored.
- Latency: out_valid rises 2*bits+1 cycles after the accept edge (65 for bits=32).
- Throughput: one product per 2*bits+3 cycles with out_ready held high.

Decomposition:
- Shared package spm_pkg holds:
  - state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2
  - a width helper for the counter, clog2(2*bits+1)
- No sub-module inside the driver; the shift/counter logic is small.
- The spm instance belongs to the integrating wrapper spm_top (driver + spm), which is the verification DUT.

Test Plan:
- Basic product, bits=32: x=3, a=5 -> out_p=64'd15, out_valid rises 65 cycles after accept, in_ready=0 throughout.
- Full-scale, bits=32: x=a=32'hFFFFFFFF -> out_p=64'hFFFFFFFE00000001. The next op x=1, a=1 gives exactly 1, proving the spm drained.
- Zero/identity, bits=8: x=0, a=8'hA5 -> 16'h0000; then x=8'hA5, a=1 -> 16'h00A5; then x=8'h80, a=8'h80 -> 16'h4000.
- Backpressure: out_ready low for 20 cycles in DONE -> out_valid and out_p stable, in_ready=0, mul_x=0. Handshake -> IDLE next cycle, in_ready=1.
- Reset mid-run: rst low at RUN cycle c=10 -> out_valid=0, mul_x=0, mul_a=0, state=IDLE immediately (asynchronous). A following x=7, a=9 -> 63.
- Random regression, bits=8 and 32, 1000 ops, random in_valid/out_ready gaps -> out_p equals the reference x*a for every op; no op lost or duplicated.
